// File: rtl/vmem_pkg.sv
// Shared types and sizing helpers for the vector memory stage.
package vmem_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        STORE     = 3'd1,
        LOAD      = 3'd2,
        LOAD_TAIL = 3'd3,
        DONE      = 3'd4
    } vmem_state_t;

    localparam int unsigned VMEM_DEFAULT_VECTOR_SIZE = 8;

    // Counter must hold the full lane count, not just the last lane index.
    function automatic int unsigned vmem_lane_cnt_w(input int unsigned lanes);
        return $clog2(lanes) + 1;
    endfunction

    localparam int unsigned VMEM_LANE_CNT_W = vmem_lane_cnt_w(VMEM_DEFAULT_VECTOR_SIZE);

endpackage

// File: rtl/vmem_lane_sequencer.sv
// Lane counter with base+lane address generation; the address wraps modulo 2^ADDR_WIDTH.
module vmem_lane_sequencer #(
    parameter int unsigned ADDR_WIDTH = 19,
    parameter int unsigned CNT_W      = vmem_pkg::VMEM_LANE_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  advance_i,
    input  logic [CNT_W-1:0]      lane_total_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    output logic [CNT_W-1:0]      lane_idx_o,
    output logic [ADDR_WIDTH-1:0] addr_c_o,
    output logic                  all_issued_c_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (advance_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign lane_idx_o     = cnt_q;
    assign addr_c_o       = base_i + ADDR_WIDTH'(cnt_q);
    assign all_issued_c_o = (cnt_q == lane_total_i);

endmodule

// File: rtl/vector_memory_stage.sv
// Memory-access stage: serialises scalar/vector loads and stores onto a byte-wide
// synchronous RAM, one lane per cycle, stalling the pipeline via busy.
module vector_memory_stage
    import vmem_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned VECTOR_SIZE = 8,
    parameter int unsigned ADDR_WIDTH  = 19
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_store,
    input  logic                         req_vector,
    input  logic [ADDR_WIDTH-1:0]        req_addr,
    input  logic [WIDTH*VECTOR_SIZE-1:0] req_wdata,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic [WIDTH-1:0]             mem_wdata,
    output logic                         mem_we,
    output logic                         mem_re,
    input  logic [WIDTH-1:0]             mem_rdata,
    output logic [WIDTH*VECTOR_SIZE-1:0] rd_data,
    output logic                         done,
    output logic                         busy
);

    localparam int unsigned CNT_W  = vmem_lane_cnt_w(VECTOR_SIZE);
    localparam int unsigned DATA_W = WIDTH * VECTOR_SIZE;

    vmem_state_t           state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  vector_q, vector_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
    logic                  mem_we_q, mem_we_d;
    logic                  mem_re_q, mem_re_d;
    logic [DATA_W-1:0]     rd_data_q, rd_data_d;
    logic                  done_q, done_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;

    logic                  seq_clear, seq_advance;
    logic [CNT_W-1:0]      lane_total;
    logic [ADDR_WIDTH-1:0] seq_base;
    logic [CNT_W-1:0]      lane_idx;
    logic [ADDR_WIDTH-1:0] seq_addr;
    logic                  all_issued;
    logic [WIDTH-1:0]      store_lane;
    logic                  cap_en;
    logic [CNT_W-1:0]      cap_idx;

    // In IDLE the request fields feed the sequencer so lane 0 goes out on the accept edge.
    assign seq_base   = (state_q == IDLE) ? req_addr : base_q;
    assign lane_total = ((state_q == IDLE) ? req_vector : vector_q) ? CNT_W'(VECTOR_SIZE) : CNT_W'(1);

    vmem_lane_sequencer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_W      (CNT_W)
    ) u_seq (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear_i        (seq_clear),
        .advance_i      (seq_advance),
        .lane_total_i   (lane_total),
        .base_i         (seq_base),
        .lane_idx_o     (lane_idx),
        .addr_c_o       (seq_addr),
        .all_issued_c_o (all_issued)
    );

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        vector_d    = vector_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        rd_data_d   = rd_data_q;
        done_d      = 1'b0;
        ready_d     = 1'b0;
        seq_clear   = 1'b0;
        seq_advance = 1'b0;
        cap_en      = 1'b0;
        cap_idx     = '0;
        store_lane  = '0;

        for (int l = 0; l < VECTOR_SIZE; l++) begin
            if (CNT_W'(l) == lane_idx) begin
                store_lane = wdata_q[l*WIDTH +: WIDTH];
            end
        end

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (req_valid) begin
                    base_d      = req_addr;
                    wdata_d     = req_wdata;
                    vector_d    = req_vector;
                    mem_addr_d  = seq_addr;
                    mem_we_d    = req_store;
                    mem_re_d    = ~req_store;
                    seq_advance = 1'b1;
                    ready_d     = 1'b0;
                    if (req_store) begin
                        mem_wdata_d = req_wdata[WIDTH-1:0];
                        state_d     = STORE;
                    end else begin
                        state_d     = LOAD;
                    end
                end
            end
            STORE: begin
                if (all_issued) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    seq_clear = 1'b1;
                end else begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = seq_addr;
                    mem_wdata_d = store_lane;
                    seq_advance = 1'b1;
                end
            end
            LOAD: begin
                // RAM returns data one cycle after issue, so capture trails issue by two lanes here.
                if (lane_idx >= CNT_W'(2)) begin
                    cap_en  = 1'b1;
                    cap_idx = lane_idx - CNT_W'(2);
                end
                if (all_issued) begin
                    state_d = LOAD_TAIL;
                end else begin
                    mem_re_d    = 1'b1;
                    mem_addr_d  = seq_addr;
                    seq_advance = 1'b1;
                end
            end
            LOAD_TAIL: begin
                if (!vector_q) begin
                    rd_data_d = '0;
                end
                cap_en    = 1'b1;
                cap_idx   = lane_idx - CNT_W'(1);
                state_d   = DONE;
                done_d    = 1'b1;
                seq_clear = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        for (int l = 0; l < VECTOR_SIZE; l++) begin
            if (cap_en && (CNT_W'(l) == cap_idx)) begin
                rd_data_d[l*WIDTH +: WIDTH] = mem_rdata;
            end
        end

        busy_d = ~ready_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            wdata_q     <= '0;
            vector_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            rd_data_q   <= '0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            vector_q    <= vector_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            rd_data_q   <= rd_data_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign rd_data   = rd_data_q;
    assign done      = done_q;

endmodule

// File: tb/tb_vector_memory_stage.sv
// Directed bench for vector_memory_stage with a byte-wide synchronous RAM model.
module tb_vector_memory_stage;

    localparam int unsigned AW = 19;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_store, req_vector;
    logic [AW-1:0] req_addr;
    logic [63:0]   req_wdata;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata, mem_rdata;
    logic          mem_we, mem_re;
    logic [63:0]   rd_data;
    logic          done, busy;

    bit [7:0] ram [0:(1<<AW)-1];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    vector_memory_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_vector (req_vector),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata),
        .rd_data    (rd_data),
        .done       (done),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one edge; returns #1 after the accept edge T0.
    task automatic accept(input logic st, input logic vec, input logic [AW-1:0] a, input logic [63:0] d);
        chk("ready_before_accept", req_ready, 1);
        req_store  = st;
        req_vector = vec;
        req_addr   = a;
        req_wdata  = d;
        req_valid  = 1'b1;
        step();
        req_valid  = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] ea;
        rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_vector = 1'b0;
        req_addr = '0; req_wdata = '0;
        step(); step();
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_re", mem_re, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        step();

        // vector store, base 0x10
        accept(1'b1, 1'b1, 19'h00010, 64'h0807060504030201);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            chk("vst_we", mem_we, 1);
            chk("vst_re", mem_re, 0);
            chk("vst_addr", mem_addr, 64'(16 + k));
            chk("vst_wdata", mem_wdata, 64'(k + 1));
            chk("vst_busy", busy, 1);
        end
        step();
        chk("vst_done", done, 1);
        chk("vst_we_off", mem_we, 0);
        chk("vst_busy_done", busy, 1);
        step();
        chk("vst_done_off", done, 0);
        chk("vst_ready", req_ready, 1);
        chk("vst_busy_off", busy, 0);
        for (int k = 0; k < 8; k++) chk("vst_ram", ram[16 + k], 64'(k + 1));

        // vector load from 0x10, with a stray request pulse mid-operation
        accept(1'b0, 1'b1, 19'h00010, 64'h0);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            chk("vld_re", mem_re, 1);
            chk("vld_we", mem_we, 0);
            chk("vld_addr", mem_addr, 64'(16 + k));
            chk("vld_busy", busy, 1);
            if (k == 3) begin req_valid = 1'b1; req_store = 1'b1; end
            if (k == 4) req_valid = 1'b0;
        end
        step();
        chk("vld_re_off", mem_re, 0);
        chk("vld_we_tail", mem_we, 0);
        chk("vld_no_early_done", done, 0);
        chk("vld_busy_tail", busy, 1);
        step();
        chk("vld_done", done, 1);
        chk("vld_rd_data", rd_data, 64'h0807060504030201);
        chk("vld_busy_done", busy, 1);
        step();
        chk("vld_busy_off", busy, 0);
        chk("vld_done_off", done, 0);

        // scalar store 0xAB at top of address space
        accept(1'b1, 1'b0, 19'h7FFFF, 64'h11223344556677AB);
        chk("sst_we", mem_we, 1);
        chk("sst_addr", mem_addr, 19'h7FFFF);
        chk("sst_wdata", mem_wdata, 8'hAB);
        step();
        chk("sst_done", done, 1);
        chk("sst_we_off", mem_we, 0);
        step();
        chk("sst_ready", req_ready, 1);
        chk("sst_ram", ram[19'h7FFFF], 8'hAB);
        chk("sst_no_spill", ram[0], 0);

        // scalar load from 0x7FFFF
        accept(1'b0, 1'b0, 19'h7FFFF, 64'h0);
        chk("sld_re", mem_re, 1);
        chk("sld_addr", mem_addr, 19'h7FFFF);
        step();
        chk("sld_re_off", mem_re, 0);
        chk("sld_no_early_done", done, 0);
        step();
        chk("sld_done", done, 1);
        chk("sld_rd_data", rd_data, 64'h00000000000000AB);
        step();
        chk("sld_ready", req_ready, 1);

        // vector store wrapping past all-ones
        accept(1'b1, 1'b1, 19'h7FFFE, 64'hF8F7F6F5F4F3F2F1);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            ea = 19'h7FFFE + 19'(k);
            chk("wrap_addr", mem_addr, ea);
            chk("wrap_wdata", mem_wdata, 64'(8'hF1 + k));
        end
        step();
        chk("wrap_done", done, 1);
        step();
        chk("wrap_ram_lo", ram[19'h7FFFE], 8'hF1);
        chk("wrap_ram_0", ram[0], 8'hF3);
        chk("wrap_ram_5", ram[5], 8'hF8);
        chk("wrap_rd_data_held", rd_data, 64'h00000000000000AB);

        // req_valid held high: one accept per operation
        req_store = 1'b1; req_vector = 1'b0; req_addr = 19'h00100; req_wdata = 64'h55;
        req_valid = 1'b1;
        step();
        chk("held_we0", mem_we, 1);
        chk("held_addr0", mem_addr, 19'h00100);
        step();
        chk("held_done", done, 1);
        chk("held_no_reaccept", mem_we, 0);
        step();
        chk("held_idle_ready", req_ready, 1);
        chk("held_idle_we", mem_we, 0);
        step();
        chk("held_second_accept", mem_we, 1);
        chk("held_second_busy", req_ready, 0);
        req_valid = 1'b0;
        step();
        chk("held_second_done", done, 1);
        step(); step();
        chk("held_no_third", mem_we, 0);
        chk("held_final_ready", req_ready, 1);

        // reset at T0+4 of a vector store
        accept(1'b1, 1'b1, 19'h00200, 64'hA8A7A6A5A4A3A2A1);
        step(); step(); step();
        chk("abort_we_pre", mem_we, 1);
        rst_n = 1'b0;
        step();
        chk("abort_we", mem_we, 0);
        chk("abort_ready", req_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_rd_data", rd_data, 0);
        chk("abort_addr", mem_addr, 0);
        rst_n = 1'b1;
        step();
        chk("abort_no_done1", done, 0);
        step();
        chk("abort_no_done2", done, 0);
        chk("abort_ram_last", ram[19'h203], 8'hA4);
        chk("abort_ram_unwritten", ram[19'h204], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vector_memory_stage.md
# vector_memory_stage

Memory-access pipeline stage directly downstream of the execute stage. It takes the execute result as a byte address and the execute store-data vector, then serialises vector and scalar loads and stores onto a single byte-wide synchronous data RAM, one lane per cycle. It asserts `busy` to stall the pipeline while working and returns a packed lane vector for write-back.

## Interface
Parameters:
- `WIDTH`, 8, lane width in bits; also the RAM data width.
- `VECTOR_SIZE`, 8, number of lanes.
- `ADDR_WIDTH`, 19, RAM byte-address width; equals the scalar data width.

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present this cycle.
- `req_ready`  out  1  high only in IDLE; a request is accepted on an edge where `req_valid & req_ready`.
- `req_store`  in  1  1 = store, 0 = load.
- `req_vector`  in  1  1 = all lanes, 0 = lane 0 only (scalar).
- `req_addr`  in  ADDR_WIDTH  base byte address, taken from execute `out[ADDR_WIDTH-1:0]`.
- `req_wdata`  in  WIDTH*VECTOR_SIZE  store data from execute `dataToWrite`; lane i is `[i*WIDTH +: WIDTH]`.
- `mem_addr`  out  ADDR_WIDTH  RAM address (registered).
- `mem_wdata`  out  WIDTH  RAM write data (registered).
- `mem_we`  out  1  RAM write enable (registered).
- `mem_re`  out  1  RAM read enable (registered).
- `mem_rdata`  in  WIDTH  RAM read data; valid in the cycle after `mem_addr`/`mem_re` were presented.
- `rd_data`  out  WIDTH*VECTOR_SIZE  load result (registered).
- `done`  out  1  one-cycle pulse when the access completes.
- `busy`  out  1  `~req_ready`; pipeline stall.

## Operation
- FSM states: IDLE, STORE, LOAD, LOAD_TAIL, DONE.
- On accept, latch `req_addr`, `req_wdata`, `req_store`, `req_vector`, and clear the lane counter.
- Lane count: `VECTOR_SIZE` when `req_vector=1`, otherwise 1.
- STORE:
  - Each cycle drive `mem_we=1`, `mem_addr=base+i`, `mem_wdata=lane i`, then increment i.
  - After the last lane, go to DONE.
- LOAD:
  - Each cycle drive `mem_re=1`, `mem_addr=base+i`.
  - Capture `mem_rdata` into `rd_data` lane i-1, one cycle behind issue.
  - After the last issue, go to LOAD_TAIL.
- LOAD_TAIL: capture the final lane, then go to DONE.
- DONE: `done=1` for exactly one cycle, then IDLE.
- Scalar load:
  - Result goes in lane 0.
  - Lanes 1..`VECTOR_SIZE-1` of `rd_data` are written to 0.
- Vector load: overwrites every lane.
- Scalar store: writes only `req_wdata[WIDTH-1:0]`.
- Address arithmetic is modulo 2^ADDR_WIDTH; `base+i` wraps silently past all-ones.
- `rd_data` holds its value until the next load overwrites it. Stores do not change it.
- `req_valid` while busy is ignored. No queueing; upstream must hold the request until accepted.

## Timing
- Reset (`rst_n=0` at an edge), from any state:
  - Next state is IDLE; `req_ready=1`.
  - `mem_we`, `mem_re`, `done`, `busy`, `mem_addr`, `mem_wdata` and `rd_data` are all 0.
  - An aborted access produces no `done`. Writes already issued are not undone.
- Let T0 be the accept edge.
- Vector store:
  - Lane i is on the RAM port during the cycle after edge T0+i, for i=0..7.
  - `done` is high after T0+8; `req_ready` returns after T0+9.
- Vector load:
  - Addresses are issued after T0..T0+7.
  - Lane i is captured at T0+i+2.
  - `done` is high after T0+9 with `rd_data` final; ready after T0+10.
- Scalar store: write after T0; `done` after T0+1.
- Scalar load: read after T0; capture at T0+2; `done` after T0+2.
- `mem_we` and `mem_re` are never high together. Both are 0 in IDLE, LOAD_TAIL and DONE.
- Back-to-back operation: the earliest next accept is at the edge ending the first IDLE cycle after DONE.

## Structure
- Shared package `vmem_pkg` contains:
  - the `vmem_state_t` enum (IDLE, STORE, LOAD, LOAD_TAIL, DONE);
  - the `VMEM_LANE_CNT_W = $clog2(VECTOR_SIZE)+1` constant.
- One sub-module, `vmem_lane_sequencer`: lane counter plus address adder (base+i with wrap), with a last-lane flag.
- The FSM and the data registers stay in the top module.

## Test plan
- Vector store, base 0x00010, `req_wdata`=0x0807060504030201 -> RAM bytes 0x10..0x17 = 01..08 on cycles T0+1..T0+8; `done` after T0+8.
- Vector load from the same base -> `rd_data`=0x0807060504030201 and `done` after T0+9; `busy` high for 10 cycles.
- Scalar store 0xAB at 0x7FFFF, then scalar load -> `rd_data`=0x00000000000000AB, `done` 2 cycles after accept.
- Wrap: vector store at base 0x7FFFE -> addresses 0x7FFFE, 0x7FFFF, 0x00000..0x00005.
- `req_valid` held high throughout -> exactly one accept per operation, next accept exactly one cycle after DONE. Pulsing `req_valid` mid-operation has no effect.
- `rst_n` low at T0+4 of a vector store -> `mem_we`=0 next cycle, no `done`, `req_ready`=1, `rd_data`=0.
